// File: rtl/fetch_buf_2p_pp_pkg.sv
// Shared encoder constants and bank-status types for the fetch ping-pong buffer.
package fetch_buf_2p_pp_pkg;

  // Encoder-wide defaults: pixel width and fetch-buffer depth in words
  localparam int ENC_PIXEL_WIDTH = 8;
  localparam int ENC_FETCH_DEPTH = 208;

  // Ping-pong status: one full flag per bank plus each side's bank pointer
  typedef struct packed {
    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
  } bank_st_t;

  localparam bank_st_t BANK_ST_RST = '{full: 2'b00, wr_bank: 1'b0, rd_bank: 1'b0};

  // Word address lies inside a bank of the given depth
  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/fetch_ram_2p_be.sv
// Single bank: 1 write port with per-lane enables, 1 read port with registered output.
module fetch_ram_2p_be #(
  parameter  int DW       = 64,
  parameter  int LANE_NUM = 2,
  parameter  int DEPTH    = 208,
  localparam int ADDR_WD  = $clog2(DEPTH),
  localparam int LW       = DW / LANE_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_NUM-1:0] we,
  input  logic [ADDR_WD-1:0]  waddr,
  input  logic [DW-1:0]       wdata,
  input  logic                re,
  input  logic [ADDR_WD-1:0]  raddr,
  output logic [DW-1:0]       rdata
);

  logic [LANE_NUM-1:0][LW-1:0] mem [DEPTH];

  // Lane-masked write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_NUM; i++)
      if (we[i]) mem[waddr][i] <= wdata[i*LW +: LW];
  end

  // Output register only moves on a read, so it holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fetch_buf_2p_pp.sv
// Two-bank ping-pong fetch buffer: writer fills one bank while the reader drains the other.
module fetch_buf_2p_pp
  import fetch_buf_2p_pp_pkg::*;
#(
  parameter  int PIXEL_WIDTH = ENC_PIXEL_WIDTH,
  parameter  int PIX_NUM     = 8,
  parameter  int LANE_NUM    = 2,
  parameter  int DEPTH       = ENC_FETCH_DEPTH,
  localparam int DW          = PIXEL_WIDTH * PIX_NUM,
  localparam int ADDR_WD     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_NUM-1:0] wr_en,
  input  logic [ADDR_WD-1:0]  wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                wr_done,
  output logic                wr_rdy,
  input  logic                rd_en,
  input  logic [ADDR_WD-1:0]  rd_addr,
  input  logic                rd_done,
  output logic                rd_rdy,
  output logic [DW-1:0]       rd_data,
  output logic                rd_vld,
  output logic                wr_bank,
  output logic                rd_bank,
  output logic                err
);

  bank_st_t st;
  logic     vld_pipe;
  logic     rd_sel;

  logic wr_req, wr_acc, rd_acc, wr_fin, rd_fin, proto_err;

  logic [1:0][LANE_NUM-1:0] bank_we;
  logic [1:0]               bank_re;
  logic [1:0][DW-1:0]       bank_q;

  // A bank is writable while empty and readable while full; the two pointers
  // can never both be ready on the same bank.
  assign wr_rdy  = ~st.full[st.wr_bank];
  assign rd_rdy  =  st.full[st.rd_bank];
  assign wr_bank = st.wr_bank;
  assign rd_bank = st.rd_bank;

  assign wr_req = |wr_en;
  assign wr_acc = wr_rdy & wr_req & addr_ok(32'(wr_addr), DEPTH);
  assign rd_acc = rd_rdy & rd_en  & addr_ok(32'(rd_addr), DEPTH);
  assign wr_fin = wr_done & wr_rdy;
  assign rd_fin = rd_done & rd_rdy;

  // Any request that cannot be honoured is dropped and flagged
  assign proto_err = (wr_req  & ~wr_acc) | (rd_en   & ~rd_acc) |
                     (wr_done & ~wr_rdy) | (rd_done & ~rd_rdy);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = (wr_acc && st.wr_bank == 1'(b)) ? wr_en : '0;
    assign bank_re[b] = rd_acc && st.rd_bank == 1'(b);

    fetch_ram_2p_be #(
      .DW       (DW),
      .LANE_NUM (LANE_NUM),
      .DEPTH    (DEPTH)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (bank_re[b]),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  // Bank handoff, read-valid, output select and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= BANK_ST_RST;
      vld_pipe <= 1'b0;
      rd_sel   <= 1'b0;
      err      <= 1'b0;
    end else begin
      // wr_fin and rd_fin always touch different banks, so both may land together
      if (wr_fin) begin
        st.full[st.wr_bank] <= 1'b1;
        st.wr_bank          <= ~st.wr_bank;
      end
      if (rd_fin) begin
        st.full[st.rd_bank] <= 1'b0;
        st.rd_bank          <= ~st.rd_bank;
      end
      vld_pipe <= rd_acc;
      if (rd_acc)    rd_sel <= st.rd_bank;
      if (proto_err) err    <= 1'b1;
    end
  end

  // Select follows the last accepted read, so the output holds between reads
  assign rd_data = bank_q[rd_sel];
  assign rd_vld  = vld_pipe;

endmodule
